// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer holding DEPTH words, fixed wait states, perror on out-of-range addresses.
module apb_slave_mem #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  perror
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [0:0] S_IDLE = 1'b0, S_ACCESS = 1'b1;
   logic [0:0]            r_state;
   logic [3:0]            r_cnt;
   logic [IW-1:0]         r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_write, r_err;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_setup_err;
   logic [DATA_WIDTH-1:0] w_setup_rd, w_acc_rd;
   // Full-width unsigned compare: out-of-range addresses never alias into the array.
   assign w_setup_err = {1'b0, paddr} >= (ADDR_WIDTH+1)'(DEPTH);
   assign w_setup_rd  = (pwrite || w_setup_err) ? '0 : r_mem[paddr[IW-1:0]];
   assign w_acc_rd    = (r_write || r_err) ? '0 : r_mem[r_addr];
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         prdata  <= '0;
         pready  <= 1'b0;
         perror  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == S_IDLE) begin
         if (psel && !penable) begin
            r_state <= S_ACCESS;
            r_addr  <= paddr[IW-1:0];
            r_wdata <= pwdata;
            r_write <= pwrite;
            r_cnt   <= 4'(WAIT_STATES);
            r_err   <= w_setup_err;
            if (WAIT_STATES == 0) begin
               pready <= 1'b1;
               perror <= w_setup_err;
               prdata <= w_setup_rd;
            end
         end
      end else if (!psel) begin
         r_state <= S_IDLE;
         prdata  <= '0;
         pready  <= 1'b0;
         perror  <= 1'b0;
      end else if (penable) begin
         if (pready) begin
            if (r_write && !r_err) r_mem[r_addr] <= r_wdata;
            r_state <= S_IDLE;
            prdata  <= '0;
            pready  <= 1'b0;
            perror  <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               pready <= 1'b1;
               perror <= r_err;
               prdata <= w_acc_rd;
            end
         end
      end
   end
endmodule
